// File: rtl/fft_pkg.sv
// fft_pkg: constants, state encoding and helpers shared by the FFT output-side blocks.
package fft_pkg;

  localparam int N_FFT              = 1024;
  localparam int NUM_BANDS          = 16;
  localparam int MAG_W              = 24;
  localparam int BIN_W              = 10;
  localparam int BINS_PER_BAND      = N_FFT / 2 / NUM_BANDS;
  localparam int BINS_PER_BAND_LOG2 = $clog2(BINS_PER_BAND);

  // SYNC waits for a frame boundary; ACCUM folds bins into bands.
  typedef enum logic {
    SYNC  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Right shift that maps a bin index onto its band for a given configuration.
  function automatic int band_shift(input int n_fft, input int num_bands);
    return $clog2(n_fft / 2 / num_bands);
  endfunction

endpackage

// File: rtl/fft_band_reader_peak.sv
// fft_peak_tracker: running maximum of bin magnitudes inside an enabled bin window.
// Strict-greater compare, so on equal magnitudes the earlier (lower) bin is kept.
module fft_peak_tracker
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic             win_en,
  input  logic [BIN_W-1:0] bin,
  input  logic [MAG_W-1:0] mag,
  output logic [BIN_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag
);

  logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;

  // Next peak: clear wins; otherwise capture a strictly larger in-window magnitude.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    if (clear) begin
      peak_bin_d = '0;
      peak_mag_d = '0;
    end else if (valid && win_en && (mag > peak_mag_q)) begin
      peak_bin_d = bin;
      peak_mag_d = mag;
    end
  end

  // Peak registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
    end
  end

  assign peak_bin = peak_bin_q;
  assign peak_mag = peak_mag_q;

endmodule

// File: rtl/fft_band_reader.sv
// fft_band_reader: folds streamed FFT bin magnitudes (bins 1..N_FFT/2-1) into NUM_BANDS
// equal-width saturating band accumulators, tracks the peak bin, and publishes one
// frame-consistent snapshot per complete frame. Short/long frames are rejected.
// Optional macro FFT_BAND_PEAK_HOLD_EN: held levels decay by one per publish instead of
// being overwritten (new = max(new_level, old_level-1)).
module fft_band_reader
  import fft_pkg::MAG_W, fft_pkg::BIN_W, fft_pkg::state_e, fft_pkg::SYNC, fft_pkg::ACCUM,
         fft_pkg::band_shift;
#(
  parameter int N_FFT       = 1024,
  parameter int NUM_BANDS   = 16,
  parameter int ACC_W       = 32,
  parameter int LEVEL_W     = 6,
  parameter int LEVEL_SHIFT = 16
) (
  input  logic                         clk100m,
  input  logic                         reset,
  input  logic [MAG_W-1:0]             freq_mag,
  input  logic                         fft_out_rdy,
  input  logic                         fft_done,
  input  logic [$clog2(NUM_BANDS)-1:0] band_sel,
  output logic [LEVEL_W-1:0]           band_level,
  output logic [BIN_W-1:0]             peak_bin,
  output logic [MAG_W-1:0]             peak_mag,
  output logic                         frame_valid,
  output logic                         frame_err
);

  localparam int CNT_W = $clog2(N_FFT) + 1;
  localparam int SEL_W = $clog2(NUM_BANDS);
  localparam int SUM_W = ACC_W + 1;
  localparam int HALF  = N_FFT / 2;
  localparam int SHIFT = band_shift(N_FFT, NUM_BANDS);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bin_cnt_q, bin_cnt_d;
  logic [ACC_W-1:0]   acc_q [NUM_BANDS];
  logic [ACC_W-1:0]   acc_d [NUM_BANDS];
  logic [LEVEL_W-1:0] level_q [NUM_BANDS];
  logic [LEVEL_W-1:0] level_d [NUM_BANDS];
  logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]   peak_mag_q, peak_mag_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               in_window;
  logic [SEL_W-1:0]   band_idx;
  logic               trk_clear;
  logic               trk_valid;
  logic [BIN_W-1:0]   cur_peak_bin;
  logic [MAG_W-1:0]   cur_peak_mag;
  logic [LEVEL_W-1:0] new_lvl;
`ifdef FFT_BAND_PEAK_HOLD_EN
  logic [LEVEL_W-1:0] decayed;
`endif

  // Saturating accumulate of one magnitude into a band.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                              input logic [MAG_W-1:0] mag);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, acc} + SUM_W'(mag);
    return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  endfunction

  // Accumulator to display level: shift down, then clamp to the level range.
  function automatic logic [LEVEL_W-1:0] to_level(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] shifted;
    shifted = acc >> LEVEL_SHIFT;
    return (shifted > ACC_W'(LEVEL_MAX)) ? LEVEL_MAX : shifted[LEVEL_W-1:0];
  endfunction

  // DC and the mirror half never contribute to bands or peak.
  assign in_window = (bin_cnt_q != '0) && (bin_cnt_q < CNT_W'(HALF));
  assign band_idx  = SEL_W'(bin_cnt_q >> SHIFT);
  assign trk_valid = (state_q == ACCUM) && fft_out_rdy;

  fft_peak_tracker u_peak (
    .clk      (clk100m),
    .reset    (reset),
    .clear    (trk_clear),
    .valid    (trk_valid),
    .win_en   (in_window),
    .bin      (BIN_W'(bin_cnt_q)),
    .mag      (freq_mag),
    .peak_bin (cur_peak_bin),
    .peak_mag (cur_peak_mag)
  );

  // Next-state, accumulation, frame-end publish/reject decisions.
  always_comb begin
    state_d       = state_q;
    bin_cnt_d     = bin_cnt_q;
    acc_d         = acc_q;
    level_d       = level_q;
    peak_bin_d    = peak_bin_q;
    peak_mag_d    = peak_mag_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    trk_clear     = 1'b0;
    new_lvl       = '0;
`ifdef FFT_BAND_PEAK_HOLD_EN
    decayed       = '0;
`endif

    case (state_q)
      SYNC: begin
        // The first frame boundary aligns us; nothing is published for it.
        if (fft_out_rdy && fft_done) begin
          state_d   = ACCUM;
          bin_cnt_d = '0;
          acc_d     = '{default: '0};
          trk_clear = 1'b1;
        end
      end

      ACCUM: begin
        if (fft_out_rdy) begin
          if (in_window) begin
            acc_d[band_idx] = sat_add(acc_q[band_idx], freq_mag);
          end
          if (bin_cnt_q != CNT_W'(N_FFT)) begin
            bin_cnt_d = bin_cnt_q + CNT_W'(1);
          end
          if (fft_done) begin
            // The last bin is always in the mirror half, so acc_q/peak are already final.
            if (bin_cnt_q == CNT_W'(N_FFT - 1)) begin
              for (int b = 0; b < NUM_BANDS; b++) begin
                new_lvl = to_level(acc_q[b]);
`ifdef FFT_BAND_PEAK_HOLD_EN
                decayed    = (level_q[b] == '0) ? '0 : level_q[b] - LEVEL_W'(1);
                level_d[b] = (new_lvl > decayed) ? new_lvl : decayed;
`else
                level_d[b] = new_lvl;
`endif
              end
              peak_bin_d    = cur_peak_bin;
              peak_mag_d    = cur_peak_mag;
              frame_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            bin_cnt_d = '0;
            acc_d     = '{default: '0};
            trk_clear = 1'b1;
          end
        end
      end

      default: state_d = SYNC;
    endcase
  end

  // State, accumulator and held-snapshot registers with synchronous reset.
  always_ff @(posedge clk100m) begin
    if (reset) begin
      state_q       <= SYNC;
      bin_cnt_q     <= '0;
      // NOTE: the band arrays are plain registers, so they are reset like any other flop.
      acc_q         <= '{default: '0};
      level_q       <= '{default: '0};
      peak_bin_q    <= '0;
      peak_mag_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bin_cnt_q     <= bin_cnt_d;
      acc_q         <= acc_d;
      level_q       <= level_d;
      peak_bin_q    <= peak_bin_d;
      peak_mag_q    <= peak_mag_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign band_level  = level_q[band_sel];
  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/fft_band_reader.md
Name: fft_band_reader

Overview:
- Consumer on the output side of the FFT wrapper.
- Reads the streamed per-bin magnitude (freq_mag with fft_out_rdy / fft_done), folds bins 1..N_FFT/2-1 into NUM_BANDS equal-width bands and tracks the peak bin.
- Publishes one frame-consistent snapshot per completed FFT for the display logic, which reads it through a band-select port.

Parameters:
- N_FFT, 1024, transform size; must equal the FFT core size.
- NUM_BANDS, 16, number of output bands; power of two ≤ N_FFT/2.
- ACC_W, 32, band accumulator width; saturating.
- LEVEL_W, 6, width of band_level.
- LEVEL_SHIFT, 16, right shift applied to the accumulator before level saturation.

Ports:
- clk100m  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- freq_mag  in  24  magnitude of the current output bin.
- fft_out_rdy  in  1  one output bin is valid this cycle.
- fft_done  in  1  asserted together with the last bin of a frame.
- band_sel  in  clog2(NUM_BANDS)  band index for display readout.
- band_level  out  LEVEL_W  level of the band selected by band_sel; combinational from held registers.
- peak_bin  out  10  bin index of the maximum magnitude in the last published frame.
- peak_mag  out  24  magnitude at peak_bin.
- frame_valid  out  1  one-cycle pulse when a new snapshot is published.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values:
  - all outputs 0;
  - held levels 0, peak_bin/peak_mag 0;
  - accumulators 0, bin_cnt 0;
  - state SYNC.
- SYNC state:
  - beats are ignored until the first fft_done beat;
  - that beat clears bin_cnt and the accumulators and moves to ACCUM;
  - no publish and no error pulse on that transition.
- ACCUM state, on each fft_out_rdy beat, with bin = bin_cnt:
  - bin_cnt saturates at N_FFT.
  - For 1 ≤ bin < N_FFT/2: acc[bin >> log2(N_FFT/2/NUM_BANDS)] += freq_mag, saturating at 2^ACC_W-1.
  - Bin 0 (DC) and bins ≥ N_FFT/2 (mirror half) are ignored.
  - Peak: for 1 ≤ bin < N_FFT/2, if freq_mag > cur_peak_mag, capture bin and magnitude. A strict compare means ties keep the lower bin.
- Frame end, on a beat with fft_done = 1 (this beat is still counted as a bin):
  - If bin_cnt == N_FFT-1, publish:
    - level[b] = min(acc[b] >> LEVEL_SHIFT, 2^LEVEL_W-1);
    - peak_bin/peak_mag take the current peak values;
    - frame_valid pulses on the next cycle.
  - Otherwise, reject: frame_err pulses on the next cycle and held outputs are unchanged.
  - Either way, in the same cycle: accumulators, peak tracker and bin_cnt are cleared; state stays ACCUM.
- Ordering: the cycle after fft_done may carry a new beat. That beat is bin 0 of the new frame, with no loss.
- fft_out_rdy = 0: nothing changes, including during a fft_done-free gap of any length.
- Latency: last beat to frame_valid is 1 cycle. Held outputs are updated in the same edge that raises frame_valid.
- band_sel out of range cannot occur when NUM_BANDS is a power of two.
- Reset mid-frame: everything is cleared and the block returns to SYNC; the partial frame is discarded silently.

Optional Feature:
- Macro: FFT_BAND_PEAK_HOLD_EN.
- Defined: each held level[b] on publish becomes max(new_level, old_level-1), floored at 0, giving a bar display with a decaying peak. Rejected frames do not decay.
- Undefined: level[b] = new_level on every publish.

Decomposition:
- Shared package fft_pkg:
  - N_FFT, MAG_W = 24, BIN_W = 10;
  - a state enum (SYNC, ACCUM);
  - derived constant BINS_PER_BAND = N_FFT/2/NUM_BANDS, with its log2.
- Sub-module fft_peak_tracker:
  - inputs: clear, valid, bin, mag, window-enable;
  - outputs: peak_bin, peak_mag;
  - strict-greater compare.
- Level shift/saturate stays inline.

Test Plan:
- Partial frame: reset, 500 beats then fft_done, then one full 1024-beat frame with mag=1 → no pulse for the partial frame; frame_valid once after the full frame.
- Flat frame: LEVEL_SHIFT=0 override, all 1024 bins mag=1 → band_level[0]=31, bands 1..15 = 32, peak_bin=1, peak_mag=1.
- Spike: bin 100 mag 0x100000, all other bins 0 → band 3 level=16, other bands 0, peak_bin=100, peak_mag=0x100000, frame_valid exactly 1 cycle after the fft_done beat.
- Saturation: ACC_W=24 override, all bins 0xFFFFFF → every band level=63 with no wrap.
- Short frame: 1000 beats with fft_done on the last → frame_err pulse; band_level, peak_bin and peak_mag keep the previous frame's values.
- FFT_BAND_PEAK_HOLD_EN defined: spike frame (band 3 level 16) followed by three all-zero frames → band 3 reads 15, 14, 13; back-to-back frames with fft_done immediately followed by a new beat lose no bins.
